// File: rtl/rolling_stats_pre_if.sv
// Bus between the price feed and the Z-score pre-processor.
// The master drives samples; the slave returns the window statistics.
interface rolling_stats_pre_if;
    logic        price_valid;
    logic [7:0]  price_in;
    logic        clear;
    logic [7:0]  current_data;
    logic [7:0]  N_mean;
    logic [15:0] N_sqr_mean;
    logic        data_valid_pre;
    logic        window_full;

    modport master (
        output price_valid, price_in, clear,
        input  current_data, N_mean, N_sqr_mean, data_valid_pre, window_full
    );

    modport slave (
        input  price_valid, price_in, clear,
        output current_data, N_mean, N_sqr_mean, data_valid_pre, window_full
    );
endinterface

// File: rtl/rolling_stats_pre.sv
// Rolling-window statistics in front of the Z-score stage.
// Keeps the last 2^WIN_LOG2 prices in a circular buffer, together with
// running sums of the samples and of their squares. Each accepted sample
// produces registered mean / mean-of-squares one cycle later.
module rolling_stats_pre #(
    parameter int WIN_LOG2 = 3
) (
    input  logic               clk,
    input  logic               rst,
    rolling_stats_pre_if.slave bus
);
    localparam int N     = 1 << WIN_LOG2;
    localparam int SUM_W = 8 + WIN_LOG2;
    localparam int SQ_W  = 16 + WIN_LOG2;

    localparam logic [WIN_LOG2-1:0] PTR_ONE  = 1;
    localparam logic [WIN_LOG2:0]   CNT_ONE  = 1;
    localparam logic [WIN_LOG2:0]   FULL_CNT = {1'b1, {WIN_LOG2{1'b0}}};

    logic [7:0]          r_buf [N];
    logic [WIN_LOG2-1:0] r_wr_ptr;
    logic [WIN_LOG2:0]   r_fill_cnt;
    logic [SUM_W-1:0]    r_sum;
    logic [SQ_W-1:0]     r_sqsum;
    logic [7:0]          r_current;
    logic [7:0]          r_mean;
    logic [15:0]         r_sqr_mean;
    logic                r_dv;

    logic                w_accept;
    logic                w_full;
    logic [7:0]          w_oldest;
    logic [15:0]         w_sq_in;
    logic [15:0]         w_sq_old;
    logic [SUM_W-1:0]    w_sum_nxt;
    logic [SQ_W-1:0]     w_sqsum_nxt;
    logic [WIN_LOG2:0]   w_fill_nxt;

    assign w_accept = bus.price_valid & ~bus.clear;
    assign w_full   = (r_fill_cnt == FULL_CNT);
    assign w_oldest = r_buf[r_wr_ptr];
    assign w_sq_in  = 16'(bus.price_in) * 16'(bus.price_in);
    assign w_sq_old = 16'(w_oldest) * 16'(w_oldest);

    // Next running sums. The evicted sample is subtracted before the new one
    // is added so the intermediate never exceeds N*max and cannot wrap; the
    // evicted value is always part of the sum, so it cannot underflow either.
    always_comb begin
        w_sum_nxt   = r_sum;
        w_sqsum_nxt = r_sqsum;
        w_fill_nxt  = r_fill_cnt;
        if (w_full) begin
            w_sum_nxt   = r_sum - SUM_W'(w_oldest) + SUM_W'(bus.price_in);
            w_sqsum_nxt = r_sqsum - SQ_W'(w_sq_old) + SQ_W'(w_sq_in);
        end else begin
            w_sum_nxt   = r_sum + SUM_W'(bus.price_in);
            w_sqsum_nxt = r_sqsum + SQ_W'(w_sq_in);
            w_fill_nxt  = r_fill_cnt + CNT_ONE;
        end
    end

    // Sample buffer: cleared only by reset; a clear leaves stale entries that
    // are never subtracted because eviction is gated by a full window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) r_buf[i] <= '0;
        end else if (w_accept) begin
            r_buf[r_wr_ptr] <= bus.price_in;
        end
    end

    // Window bookkeeping and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_fill_cnt <= '0;
            r_sum      <= '0;
            r_sqsum    <= '0;
            r_current  <= '0;
            r_mean     <= '0;
            r_sqr_mean <= '0;
            r_dv       <= 1'b0;
        end else if (bus.clear) begin
            r_wr_ptr   <= '0;
            r_fill_cnt <= '0;
            r_sum      <= '0;
            r_sqsum    <= '0;
            r_current  <= '0;
            r_mean     <= '0;
            r_sqr_mean <= '0;
            r_dv       <= 1'b0;
        end else if (w_accept) begin
            r_wr_ptr   <= r_wr_ptr + PTR_ONE;
            r_fill_cnt <= w_fill_nxt;
            r_sum      <= w_sum_nxt;
            r_sqsum    <= w_sqsum_nxt;
            r_current  <= bus.price_in;
            r_mean     <= w_sum_nxt[WIN_LOG2 +: 8];
            r_sqr_mean <= w_sqsum_nxt[WIN_LOG2 +: 16];
            r_dv       <= (w_fill_nxt == FULL_CNT);
        end else begin
            r_dv       <= 1'b0;
        end
    end

    assign bus.current_data   = r_current;
    assign bus.N_mean         = r_mean;
    assign bus.N_sqr_mean     = r_sqr_mean;
    assign bus.data_valid_pre = r_dv;
    assign bus.window_full    = w_full;
endmodule

// File: tb/tb_rolling_stats_pre.sv
// Directed and random checks for rolling_stats_pre (N = 8).
module tb_rolling_stats_pre;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    rolling_stats_pre_if bus ();

    rolling_stats_pre #(.WIN_LOG2(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {current_data, N_mean, N_sqr_mean, data_valid_pre, window_full}
    logic [33:0] obs;
    assign obs = {bus.current_data, bus.N_mean, bus.N_sqr_mean,
                  bus.data_valid_pre, bus.window_full};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] v);
        bus.price_valid = 1'b1;
        bus.price_in    = v;
        tick();
        bus.price_valid = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        total++;
        if (obs !== 34'd0) begin
            bad++;
            $display("FAIL reset_initial: got %h want %h", obs, 34'd0);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) send(8'd9);
        // assert reset between edges; outputs must clear without a clock
        #3;
        rst = 1'b1;
        #1;
        total++;
        if (obs !== 34'd0) begin
            bad++;
            $display("FAIL reset_async: got %h want %h", obs, 34'd0);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_warmup();
        for (int i = 0; i < 7; i++) begin
            send(8'd10);
            total++;
            if (obs[1:0] !== 2'b00) begin
                bad++;
                $display("FAIL warmup_early[%0d]: got dv/full %b want 00", i, obs[1:0]);
            end
        end
        send(8'd10);
        total++;
        if (obs !== {8'd10, 8'd10, 16'd100, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL warmup_full: got %h want %h", obs, {8'd10, 8'd10, 16'd100, 1'b1, 1'b1});
        end
        tick();
        total++;
        if (obs !== {8'd10, 8'd10, 16'd100, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL warmup_idle: got %h want %h", obs, {8'd10, 8'd10, 16'd100, 1'b0, 1'b1});
        end
    endtask

    task automatic test_wrap();
        send(8'd18);
        total++;
        if (obs !== {8'd18, 8'd11, 16'd128, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL wrap_first: got %h want %h", obs, {8'd18, 8'd11, 16'd128, 1'b1, 1'b1});
        end
        for (int i = 0; i < 7; i++) begin
            send(8'd18);
            total++;
            if (obs[1:0] !== 2'b11) begin
                bad++;
                $display("FAIL wrap_strobe[%0d]: got %b want 11", i, obs[1:0]);
            end
        end
        total++;
        if (obs !== {8'd18, 8'd18, 16'd324, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL wrap_final: got %h want %h", obs, {8'd18, 8'd18, 16'd324, 1'b1, 1'b1});
        end
    endtask

    task automatic test_extremes();
        for (int i = 0; i < 8; i++) send(8'd255);
        total++;
        if (obs !== {8'd255, 8'd255, 16'd65025, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL extreme_max: got %h want %h", obs, {8'd255, 8'd255, 16'd65025, 1'b1, 1'b1});
        end
        for (int i = 0; i < 8; i++) send(8'd0);
        total++;
        if (obs !== {8'd0, 8'd0, 16'd0, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL extreme_zero: got %h want %h", obs, {8'd0, 8'd0, 16'd0, 1'b1, 1'b1});
        end
    endtask

    task automatic test_gapped();
        logic [7:0]  mean_t [4] = '{8'd2, 8'd5, 8'd7, 8'd10};
        logic [15:0] sq_t   [4] = '{16'd50, 16'd100, 16'd150, 16'd200};
        for (int k = 0; k < 4; k++) begin
            send(8'd20);
            total++;
            if (obs !== {8'd20, mean_t[k], sq_t[k], 1'b1, 1'b1}) begin
                bad++;
                $display("FAIL gapped_send[%0d]: got %h want %h", k, obs, {8'd20, mean_t[k], sq_t[k], 1'b1, 1'b1});
            end
            for (int g = 0; g < 2; g++) begin
                tick();
                total++;
                if (obs !== {8'd20, mean_t[k], sq_t[k], 1'b0, 1'b1}) begin
                    bad++;
                    $display("FAIL gapped_hold[%0d.%0d]: got %h want %h", k, g, obs, {8'd20, mean_t[k], sq_t[k], 1'b0, 1'b1});
                end
            end
        end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 4; i++) send(8'd50);
        bus.clear = 1'b1;
        send(8'd200);
        bus.clear = 1'b0;
        total++;
        if (obs !== 34'd0) begin
            bad++;
            $display("FAIL clear_with_valid: got %h want %h", obs, 34'd0);
        end
        tick();
        total++;
        if (obs !== 34'd0) begin
            bad++;
            $display("FAIL clear_idle: got %h want %h", obs, 34'd0);
        end
        for (int i = 1; i <= 7; i++) begin
            send(8'(i));
            total++;
            if (obs[1:0] !== 2'b00) begin
                bad++;
                $display("FAIL clear_refill[%0d]: got dv/full %b want 00", i, obs[1:0]);
            end
        end
        send(8'd8);
        total++;
        if (obs !== {8'd8, 8'd4, 16'd25, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL clear_refull: got %h want %h", obs, {8'd8, 8'd4, 16'd25, 1'b1, 1'b1});
        end
    endtask

    task automatic test_random();
        int          q[$];
        logic [7:0]  e_cd;
        logic [7:0]  e_mean;
        logic [15:0] e_sq;
        logic        e_dv;
        logic        v;
        logic        c;
        logic [7:0]  p;
        int          s;
        int          s2;
        int          nfail;
        nfail = 0;
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        e_cd = 0; e_mean = 0; e_sq = 0;
        for (int n = 0; n < 1000; n++) begin
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 49) == 0);
            p = 8'($urandom_range(0, 255));
            bus.price_valid = v;
            bus.clear       = c;
            bus.price_in    = p;
            tick();
            bus.price_valid = 1'b0;
            bus.clear       = 1'b0;
            e_dv = 1'b0;
            if (c) begin
                q.delete();
                e_cd = 0; e_mean = 0; e_sq = 0;
            end else if (v) begin
                q.push_back(int'(p));
                if (q.size() > 8) void'(q.pop_front());
                s = 0; s2 = 0;
                foreach (q[i]) begin
                    s  += q[i];
                    s2 += q[i] * q[i];
                end
                e_cd   = p;
                e_mean = 8'(s / 8);
                e_sq   = 16'(s2 / 8);
                e_dv   = (q.size() == 8);
            end
            total++;
            if (obs !== {e_cd, e_mean, e_sq, e_dv, q.size() == 8}) begin
                bad++;
                nfail++;
                if (nfail <= 10)
                    $display("FAIL random[%0d]: got %h want %h", n, obs, {e_cd, e_mean, e_sq, e_dv, q.size() == 8});
            end
        end
    endtask

    initial begin
        total           = 0;
        bad             = 0;
        rst             = 1'b1;
        bus.price_valid = 1'b0;
        bus.price_in    = 8'd0;
        bus.clear       = 1'b0;
        test_reset();
        test_warmup();
        test_wrap();
        test_extremes();
        test_gapped();
        test_clear();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
